mux2_rr_arbiter: RTL and testbench

- Round-robin arbiter and sequencer for a shared 2:1 datapath mux (A/B inputs, S select, Z output).
- Two valid/ready requesters compete for one registered output stream. A grant is held for a whole packet, delimited by LAST.
- Drives S to the shared mux and checks for runaway packets with a beat watchdog.
- Sits between two producer channels and a single downstream consumer in the cell-based datapath.

---
 rtl/mux2_rr_arbiter.sv | 161 ++++++++++++++++
 tb/tb_mux2_rr_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux2_rr_arbiter.sv
// Round-robin packet arbiter driving a shared 2:1 mux select.
// Registered output stage with a per-packet beat watchdog.
module mux2_rr_arbiter #(
  parameter int WIDTH    = 8,
  parameter int MAXBEATS = 16
) (
  input  logic             CK,
  input  logic             RN,
  input  logic             A_VALID,
  input  logic [WIDTH-1:0] A_DATA,
  input  logic             A_LAST,
  output logic             A_READY,
  input  logic             B_VALID,
  input  logic [WIDTH-1:0] B_DATA,
  input  logic             B_LAST,
  output logic             B_READY,
  output logic             Z_VALID,
  output logic [WIDTH-1:0] Z_DATA,
  output logic             Z_LAST,
  input  logic             Z_READY,
  output logic             S,
  output logic             BUSY,
  output logic             ERR
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_A = 2'd1,
    GNT_B = 2'd2
  } state_t;

  localparam logic [7:0] MAXB = 8'(MAXBEATS);

  state_t state_q, state_d;

  logic             z_valid_q, z_valid_d;
  logic [WIDTH-1:0] z_data_q, z_data_d;
  logic             z_last_q, z_last_d;
  logic             s_q, s_d;
  logic             err_q, err_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             ptr_q, ptr_d;

  logic             space;
  logic             a_rdy;
  logic             b_rdy;
  logic             xfer;
  logic             in_last;
  logic [WIDTH-1:0] in_data;
  logic [7:0]       cnt_inc;
  logic             cnt_full;
  logic             eop;

  // ptr_q: 0 = A served last, 1 = B served last
  always_comb begin
    space    = !z_valid_q || Z_READY;
    a_rdy    = RN && (state_q == GNT_A) && space;
    b_rdy    = RN && (state_q == GNT_B) && space;
    xfer     = (A_VALID && a_rdy) || (B_VALID && b_rdy);
    in_data  = s_q ? B_DATA : A_DATA;
    in_last  = s_q ? B_LAST : A_LAST;
    cnt_inc  = cnt_q + 8'd1;
    cnt_full = (cnt_inc == MAXB);
    eop      = xfer && (in_last || cnt_full);
  end

  always_ff @(posedge CK) begin
    if (!RN) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (A_VALID && (!B_VALID || ptr_q)) begin
          state_d = GNT_A;
        end else if (B_VALID) begin
          state_d = GNT_B;
        end
      end
      GNT_A: begin
        if (eop) begin
          state_d = B_VALID ? GNT_B : IDLE;
        end
      end
      GNT_B: begin
        if (eop) begin
          state_d = A_VALID ? GNT_A : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    z_valid_d = z_valid_q;
    z_data_d  = z_data_q;
    z_last_d  = z_last_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    err_d     = err_q;
    s_d       = s_q;
    if (xfer) begin
      z_valid_d = 1'b1;
      z_data_d  = in_data;
      z_last_d  = in_last;
      cnt_d     = cnt_inc;
    end else if (Z_READY) begin
      z_valid_d = 1'b0;
    end
    if (eop) begin
      cnt_d = 8'd0;
      ptr_d = s_q;
    end
    if (xfer && cnt_full && !in_last) begin
      err_d = 1'b1;
    end
    // select follows the grant; it holds while idle
    unique case (1'b1)
      (state_d == GNT_A): s_d = 1'b0;
      (state_d == GNT_B): s_d = 1'b1;
      default:            s_d = s_q;
    endcase
  end

  always_ff @(posedge CK) begin
    if (!RN) begin
      z_valid_q <= 1'b0;
      z_data_q  <= '0;
      z_last_q  <= 1'b0;
      cnt_q     <= 8'd0;
      ptr_q     <= 1'b1;
      err_q     <= 1'b0;
      s_q       <= 1'b0;
    end else begin
      z_valid_q <= z_valid_d;
      z_data_q  <= z_data_d;
      z_last_q  <= z_last_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      err_q     <= err_d;
      s_q       <= s_d;
    end
  end

  always_comb begin
    A_READY = a_rdy;
    B_READY = b_rdy;
    Z_VALID = z_valid_q;
    Z_DATA  = z_data_q;
    Z_LAST  = z_last_q;
    S       = s_q;
    BUSY    = (state_q != IDLE);
    ERR     = err_q;
  end

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Bench for mux2_rr_arbiter: directed scenarios plus a
// randomized run against a behavioural model.
module tb_mux2_rr_arbiter;

  localparam int MAXB = 16;

  logic       CK = 1'b0;
  logic       RN = 1'b0;
  logic       av = 1'b0, al = 1'b0, bv = 1'b0, bl = 1'b0;
  logic [7:0] ad = '0, bd = '0;
  logic       zr = 1'b0;
  logic       A_READY, B_READY, Z_VALID, Z_LAST, S, BUSY, ERR;
  logic [7:0] Z_DATA;

  int n_tests = 0;
  int n_fail  = 0;

  mux2_rr_arbiter #(.WIDTH(8), .MAXBEATS(MAXB)) dut (
    .CK(CK), .RN(RN),
    .A_VALID(av), .A_DATA(ad), .A_LAST(al), .A_READY(A_READY),
    .B_VALID(bv), .B_DATA(bd), .B_LAST(bl), .B_READY(B_READY),
    .Z_VALID(Z_VALID), .Z_DATA(Z_DATA), .Z_LAST(Z_LAST),
    .Z_READY(zr), .S(S), .BUSY(BUSY), .ERR(ERR)
  );

  always #5 CK = ~CK;

  initial begin
    #1000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic do_reset();
    RN = 1'b0; av = 1'b0; bv = 1'b0; al = 1'b0; bl = 1'b0; zr = 1'b1;
    repeat (2) @(posedge CK);
    #1;
    RN = 1'b1;
  endtask

  task automatic test_reset();
    RN = 1'b0; av = 1'b1; bv = 1'b1; zr = 1'b1; ad = 8'hFF; bd = 8'hEE;
    repeat (2) @(posedge CK);
    #1;
    n_tests++; if (Z_VALID !== 1'b0) begin n_fail++; $display("FAIL rst_zvalid got=%b exp=0", Z_VALID); end
    n_tests++; if (Z_DATA !== 8'h00) begin n_fail++; $display("FAIL rst_zdata got=%h exp=00", Z_DATA); end
    n_tests++; if (Z_LAST !== 1'b0) begin n_fail++; $display("FAIL rst_zlast got=%b exp=0", Z_LAST); end
    n_tests++; if (S !== 1'b0) begin n_fail++; $display("FAIL rst_s got=%b exp=0", S); end
    n_tests++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL rst_busy got=%b exp=0", BUSY); end
    n_tests++; if (ERR !== 1'b0) begin n_fail++; $display("FAIL rst_err got=%b exp=0", ERR); end
    n_tests++; if (A_READY !== 1'b0 || B_READY !== 1'b0) begin n_fail++; $display("FAIL rst_ready got=%b%b exp=00", A_READY, B_READY); end
    RN = 1'b1;
    @(posedge CK); #1;
    n_tests++; if (BUSY !== 1'b1 || S !== 1'b0) begin n_fail++; $display("FAIL rst_tie_grant got=busy%b s%b exp=busy1 s0", BUSY, S); end
    n_tests++; if (A_READY !== 1'b1 || B_READY !== 1'b0) begin n_fail++; $display("FAIL rst_tie_ready got=%b%b exp=10", A_READY, B_READY); end
  endtask

  task automatic test_single_packet();
    logic [7:0] d [3];
    d[0] = 8'h11; d[1] = 8'h22; d[2] = 8'h33;
    do_reset();
    av = 1'b1; ad = d[0]; al = 1'b0; zr = 1'b1;
    n_tests++; if (A_READY !== 1'b0) begin n_fail++; $display("FAIL single_idle_ready got=%b exp=0", A_READY); end
    @(posedge CK); #1;
    for (int i = 0; i < 3; i++) begin
      ad = d[i]; al = (i == 2);
      #1;
      n_tests++; if (A_READY !== 1'b1 || S !== 1'b0) begin n_fail++; $display("FAIL single_ready beat%0d got=rdy%b s%b exp=rdy1 s0", i, A_READY, S); end
      @(posedge CK); #1;
      n_tests++; if (Z_VALID !== 1'b1 || Z_DATA !== d[i]) begin n_fail++; $display("FAIL single_z beat%0d got=%b/%h exp=1/%h", i, Z_VALID, Z_DATA, d[i]); end
      n_tests++; if (Z_LAST !== (i == 2)) begin n_fail++; $display("FAIL single_last beat%0d got=%b exp=%b", i, Z_LAST, (i == 2)); end
    end
    n_tests++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL single_release got=%b exp=0", BUSY); end
    av = 1'b0; al = 1'b0;
    @(posedge CK); #1;
    n_tests++; if (Z_VALID !== 1'b0) begin n_fail++; $display("FAIL single_drain got=%b exp=0", Z_VALID); end
  endtask

  task automatic test_back_to_back();
    int na_pkt, na_beat, nb_pkt, nb_beat, side;
    logic sa, sb;
    logic [7:0] exp_d;
    do_reset();
    na_pkt = 0; na_beat = 0; nb_pkt = 0; nb_beat = 0;
    av = 1'b1; bv = 1'b1; zr = 1'b1;
    ad = 8'hA0; al = 1'b0; bd = 8'hB0; bl = 1'b0;
    @(posedge CK); #1;
    for (int k = 0; k < 8; k++) begin
      ad = 8'(8'hA0 + na_pkt * 2 + na_beat); al = (na_beat == 1);
      bd = 8'(8'hB0 + nb_pkt * 2 + nb_beat); bl = (nb_beat == 1);
      side  = (k / 2) % 2;
      exp_d = 8'((side != 0 ? 8'hB0 : 8'hA0) + (k / 4) * 2 + (k % 2));
      #1;
      n_tests++; if (S !== side[0] || BUSY !== 1'b1) begin n_fail++; $display("FAIL b2b_sel k%0d got=s%b busy%b exp=s%0d busy1", k, S, BUSY, side); end
      sa = A_READY; sb = B_READY;
      @(posedge CK); #1;
      n_tests++; if (Z_VALID !== 1'b1 || Z_DATA !== exp_d) begin n_fail++; $display("FAIL b2b_z k%0d got=%b/%h exp=1/%h", k, Z_VALID, Z_DATA, exp_d); end
      n_tests++; if (Z_LAST !== ((k % 2) == 1)) begin n_fail++; $display("FAIL b2b_last k%0d got=%b exp=%0d", k, Z_LAST, k % 2); end
      if (sa) begin na_beat++; if (na_beat == 2) begin na_beat = 0; na_pkt++; end end
      if (sb) begin nb_beat++; if (nb_beat == 2) begin nb_beat = 0; nb_pkt++; end end
    end
    av = 1'b0; bv = 1'b0;
  endtask

  task automatic test_stall();
    int nacc, nout;
    logic sa, sz;
    do_reset();
    nacc = 0; nout = 0;
    for (int c = 0; c < 30 && nout < 6; c++) begin
      av = (nacc < 6); ad = 8'(8'h40 + nacc); al = (nacc == 5);
      zr = !(c >= 4 && c < 8);
      #1;
      if (!zr) begin
        n_tests++; if (A_READY !== 1'b0) begin n_fail++; $display("FAIL stall_ready c%0d got=%b exp=0", c, A_READY); end
        n_tests++; if (Z_VALID !== 1'b1 || Z_DATA !== 8'(8'h40 + nout)) begin n_fail++; $display("FAIL stall_hold c%0d got=%b/%h exp=1/%h", c, Z_VALID, Z_DATA, 8'(8'h40 + nout)); end
      end
      sa = av && A_READY;
      sz = Z_VALID && zr;
      if (sz) begin
        n_tests++; if (Z_DATA !== 8'(8'h40 + nout) || Z_LAST !== (nout == 5)) begin n_fail++; $display("FAIL stall_seq n%0d got=%h/%b exp=%h/%b", nout, Z_DATA, Z_LAST, 8'(8'h40 + nout), (nout == 5)); end
        nout++;
      end
      @(posedge CK); #1;
      if (sa) nacc++;
    end
    n_tests++; if (nout != 6 || nacc != 6) begin n_fail++; $display("FAIL stall_count got=out%0d acc%0d exp=6/6", nout, nacc); end
    av = 1'b0; al = 1'b0; zr = 1'b1;
  endtask

  task automatic test_watchdog();
    int nb;
    logic sb, idle_seen;
    do_reset();
    nb = 0; idle_seen = 1'b0;
    bv = 1'b1; bl = 1'b0; zr = 1'b1;
    for (int c = 0; c < 40 && nb < 20; c++) begin
      bd = 8'(nb);
      #1;
      if (nb == 16 && !idle_seen) begin
        idle_seen = 1'b1;
        n_tests++; if (B_READY !== 1'b0) begin n_fail++; $display("FAIL wd_regrant got=%b exp=0", B_READY); end
      end
      sb = B_READY;
      @(posedge CK); #1;
      if (sb) begin
        nb++;
        n_tests++; if (Z_DATA !== 8'(nb - 1)) begin n_fail++; $display("FAIL wd_data beat%0d got=%h exp=%h", nb, Z_DATA, 8'(nb - 1)); end
        if (nb == 16) begin
          n_tests++; if (ERR !== 1'b1 || BUSY !== 1'b0 || Z_LAST !== 1'b0) begin n_fail++; $display("FAIL wd_fire got=err%b busy%b last%b exp=err1 busy0 last0", ERR, BUSY, Z_LAST); end
        end else begin
          n_tests++; if (ERR !== (nb > 16)) begin n_fail++; $display("FAIL wd_err beat%0d got=%b exp=%b", nb, ERR, (nb > 16)); end
        end
      end
    end
    n_tests++; if (nb != 20 || ERR !== 1'b1) begin n_fail++; $display("FAIL wd_end got=beats%0d err%b exp=20/1", nb, ERR); end
  endtask

  task automatic test_reset_mid();
    bv = 1'b1; bd = 8'h5A; bl = 1'b0; zr = 1'b0;
    @(posedge CK); #1;
    n_tests++; if (S !== 1'b1 || BUSY !== 1'b1 || Z_VALID !== 1'b1 || ERR !== 1'b1) begin n_fail++; $display("FAIL rmid_pre got=s%b busy%b zv%b err%b exp=1111", S, BUSY, Z_VALID, ERR); end
    RN = 1'b0; av = 1'b1; bv = 1'b1;
    @(posedge CK); #1;
    n_tests++; if (Z_VALID !== 1'b0 || S !== 1'b0 || BUSY !== 1'b0 || ERR !== 1'b0) begin n_fail++; $display("FAIL rmid_post got=zv%b s%b busy%b err%b exp=0000", Z_VALID, S, BUSY, ERR); end
    RN = 1'b1; zr = 1'b1;
    @(posedge CK); #1;
    n_tests++; if (S !== 1'b0 || BUSY !== 1'b1 || A_READY !== 1'b1 || B_READY !== 1'b0) begin n_fail++; $display("FAIL rmid_tie got=s%b busy%b rdy%b%b exp=s0 busy1 rdy10", S, BUSY, A_READY, B_READY); end
    av = 1'b0; bv = 1'b0;
  endtask

  task automatic test_valid_gap();
    int na;
    logic sa, done;
    do_reset();
    na = 0; done = 1'b0;
    bv = 1'b1; bd = 8'hBB; bl = 1'b1; zr = 1'b1;
    for (int c = 0; c < 20 && !done; c++) begin
      av = (na < 5) && !(c >= 3 && c <= 5);
      ad = 8'(8'h60 + na); al = (na == 4);
      #1;
      if (na < 5) begin
        n_tests++; if (S !== 1'b0 || B_READY !== 1'b0) begin n_fail++; $display("FAIL gap_hold c%0d got=s%b brdy%b exp=s0 brdy0", c, S, B_READY); end
      end
      sa = av && A_READY;
      @(posedge CK); #1;
      if (sa) begin
        na++;
        n_tests++; if (Z_DATA !== 8'(8'h60 + na - 1)) begin n_fail++; $display("FAIL gap_data beat%0d got=%h exp=%h", na, Z_DATA, 8'(8'h60 + na - 1)); end
      end
      if (na == 5) begin
        done = 1'b1;
        n_tests++; if (S !== 1'b1 || BUSY !== 1'b1) begin n_fail++; $display("FAIL gap_switch got=s%b busy%b exp=s1 busy1", S, BUSY); end
      end
    end
    n_tests++; if (!done) begin n_fail++; $display("FAIL gap_timeout got=beats%0d exp=5", na); end
    av = 1'b0; bv = 1'b0;
  endtask

  // Reference: owner 0 = none, 1 = A, 2 = B; last_b = B served last.
  task automatic test_random();
    int own, own0, cnt;
    logic last_b, m_zv, m_zl, m_s, m_err, m_sp, m_ar, m_br, from_b;
    logic [7:0] m_zd;
    do_reset();
    own = 0; cnt = 0; last_b = 1'b1;
    m_zv = 1'b0; m_zl = 1'b0; m_zd = 8'h00; m_s = 1'b0; m_err = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      RN = ($urandom % 400) != 0;
      av = ($urandom % 3) != 0; ad = 8'($urandom); al = ($urandom % 10) == 0;
      bv = ($urandom % 3) != 0; bd = 8'($urandom); bl = ($urandom % 24) == 0;
      zr = ($urandom % 4) != 0;
      #1;
      m_sp = !m_zv || zr;
      m_ar = RN && own == 1 && m_sp;
      m_br = RN && own == 2 && m_sp;
      n_tests++; if (A_READY !== m_ar) begin n_fail++; $display("FAIL rnd_ardy c%0d got=%b exp=%b", c, A_READY, m_ar); end
      n_tests++; if (B_READY !== m_br) begin n_fail++; $display("FAIL rnd_brdy c%0d got=%b exp=%b", c, B_READY, m_br); end
      n_tests++; if (BUSY !== (own != 0)) begin n_fail++; $display("FAIL rnd_busy c%0d got=%b exp=%b", c, BUSY, (own != 0)); end
      n_tests++; if (S !== m_s) begin n_fail++; $display("FAIL rnd_s c%0d got=%b exp=%b", c, S, m_s); end
      n_tests++; if (Z_VALID !== m_zv || Z_DATA !== m_zd || Z_LAST !== m_zl) begin n_fail++; $display("FAIL rnd_z c%0d got=%b/%h/%b exp=%b/%h/%b", c, Z_VALID, Z_DATA, Z_LAST, m_zv, m_zd, m_zl); end
      n_tests++; if (ERR !== m_err) begin n_fail++; $display("FAIL rnd_err c%0d got=%b exp=%b", c, ERR, m_err); end
      if (!RN) begin
        own = 0; cnt = 0; last_b = 1'b1;
        m_zv = 1'b0; m_zl = 1'b0; m_zd = 8'h00; m_s = 1'b0; m_err = 1'b0;
      end else begin
        own0 = own;
        if ((av && m_ar) || (bv && m_br)) begin
          from_b = (own == 2);
          m_zv = 1'b1;
          m_zd = from_b ? bd : ad;
          m_zl = from_b ? bl : al;
          cnt++;
          if (m_zl || cnt == MAXB) begin
            if (!m_zl) m_err = 1'b1;
            last_b = from_b;
            cnt = 0;
            if (from_b) own = av ? 1 : 0;
            else        own = bv ? 2 : 0;
          end
        end else if (zr) begin
          m_zv = 1'b0;
        end
        if (own0 == 0) begin
          if (av && (!bv || last_b)) own = 1;
          else if (bv)               own = 2;
        end
        if (own == 1) m_s = 1'b0;
        else if (own == 2) m_s = 1'b1;
      end
      @(posedge CK); #1;
    end
    RN = 1'b1; av = 1'b0; bv = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_packet();
    test_back_to_back();
    test_stall();
    test_watchdog();
    test_reset_mid();
    test_valid_gap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
